sd_block_writer: RTL and testbench
==================================

Name: sd_block_writer

Overview:
SPI-mode SD host engine that writes one block to an already-initialised card with CMD24 (WRITE_BLOCK). It is the write-direction counterpart of the team's SD block reader and shares the same pins, SPI mode 0 and clock-divider scheme. Block payload bytes arrive from the system through a valid/ready stream. The engine reports completion and a coded error status.

Parameters:
CLK_DIV, 4, clk cycles per SCLK period; even, >=2; SCLK high and low for CLK_DIV/2 cycles each.
BLOCK_BYTES, 512, payload bytes per block.
RESP_TIMEOUT, 8, max 0xFF poll bytes while waiting for R1.
BUSY_TIMEOUT, 65535, max poll bytes while the card signals busy.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only while busy=0
block_addr  in  32  CMD24 argument, latched on accepted start
wr_data  in  8  payload byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  engine accepts wr_data this cycle
busy  out  1  high from accepted start through the done cycle
done  out  1  one-cycle completion pulse
error  out  1  valid with done; 1 = failed
err_code  out  3  0 ok, 1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout; held until next accepted start
sclk  out  1  SPI clock, idle low
cs  out  1  chip select, active low
mosi  out  1  SPI data to card, idle high
miso  in  1  SPI data from card

Behaviour:
- Reset (asynchronous, any state): state IDLE; cs=1, sclk=0, mosi=1, wr_ready=0, busy=0, done=0, error=0, err_code=0; all counters cleared.
- Byte engine, SPI mode 0, MSB first:
  - mosi is set to bit7 while sclk is low.
  - After CLK_DIV/2 cycles sclk rises and miso is sampled.
  - After another CLK_DIV/2 cycles sclk falls and mosi moves to the next bit.
  - A byte completes on the 8th falling edge. 0 or 1 idle clk between bytes is allowed; the bench checks edges, not gaps.
- FSM states:
  - IDLE: on start, latch block_addr, set busy=1, cs=0, go to CMD.
  - CMD: send 6 bytes: 0x58, addr[31:24], [23:16], [15:8], [7:0], 0xFF (CRC ignored in SPI mode).
  - R1: send 0xFF and receive each byte. The first byte with bit7=0 is R1.
    - R1=0x00: go to GAP.
    - R1 nonzero: FAIL, code 2.
    - No R1 after RESP_TIMEOUT bytes: FAIL, code 1.
  - GAP: send one 0xFF byte.
  - TOKEN: send 0xFE.
  - DATA: at each byte boundary assert wr_ready. A transfer occurs when wr_valid&wr_ready; wr_ready drops the same cycle and the byte is shifted out.
    - While wr_valid=0: sclk stays low, cs stays low, no clocks are issued.
    - Exactly BLOCK_BYTES transfers, then go to CRC.
    - wr_ready=0 in every other state.
  - CRC: send 0xFF, 0xFF.
  - DRESP: send 0xFF and receive one byte.
    - (byte & 0x1F)==0x05: go to BUSYW.
    - Otherwise: FAIL, code 3.
  - BUSYW: send 0xFF bytes until a received byte is nonzero, then go to FIN. If BUSY_TIMEOUT bytes pass with all zero: FAIL, code 4.
  - FAIL: record err_code, then go to FIN.
  - FIN: cs=1, send one 0xFF byte (8 trailing clocks). Then pulse done for 1 cycle with error=(err_code!=0). busy drops the cycle after done. Return to IDLE.
- start while busy=1 is ignored.
- A start on the same cycle as done is ignored; the earliest accepted start is the cycle after done.
- Byte and poll counters are at least 16 bits; the payload counter counts 0..BLOCK_BYTES-1 with no wrap.

Test Plan:
1. Nominal: block_addr=0x00001234; card returns 0xFF, 0xFF, then R1=0x00; data response 0xE5; busy 0x00 x3 then 0xFF; payload = byte index mod 256 -> MOSI carries 58 00 00 12 34 FF, poll bytes, FF, FE, the 512 payload bytes in order, FF FF. Expect exactly 512 wr handshakes, done=1, error=0, err_code=0, cs=1 at done.
2. miso held at 1 -> after 8 R1 poll bytes: done=1, error=1, err_code=1; 0xFE never sent; wr_ready never asserted.
3. R1=0x04 -> done, err_code=2; no token sent.
4. Data response 0x0B -> done, err_code=3 immediately after the CRC bytes; no busy polling.
5. Back-pressure: wr_valid low for 20 cycles before payload byte 100 -> sclk stays low and cs stays low throughout the stall; payload order is intact; the nominal result is still obtained.
6. rst_n asserted mid-DATA (byte 300) -> cs=1, sclk=0, mosi=1, busy=0 without waiting for a clk edge. A new start after release completes the nominal sequence.

Source files
------------

// File: rtl/sd_block_writer.sv
// SPI-mode SD host engine: writes one block to an initialised card with CMD24,
// payload taken from a valid/ready byte stream; reports done plus an error code.
module sd_block_writer #(
    parameter int CLK_DIV      = 4,
    parameter int BLOCK_BYTES  = 512,
    parameter int RESP_TIMEOUT = 8,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] block_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC,
        S_DRESP, S_BUSYW, S_FAIL, S_FIN, S_DONE
    } state_t;

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF - 1);
    localparam logic [15:0]      RESP_LAST = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0]      BUSY_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0]      PAY_LAST  = 16'(BLOCK_BYTES - 1);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] pay_cnt_reg, pay_cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [2:0]  err_code_reg, err_code_next;

    logic             active_reg;
    logic             sclk_reg;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       tx_reg;
    logic [7:0]       rx_reg;

    logic       byte_start;
    logic       byte_done;
    logic [7:0] tx_byte;
    logic [7:0] cmd_frame [8];

    // CMD24 frame: opcode, four address bytes MSB first, then dummy CRC/padding.
    for (genvar gi = 0; gi < 8; gi++) begin : g_cmd
        if (gi == 0) begin : g_op
            assign cmd_frame[gi] = 8'h58;
        end else if (gi <= 4) begin : g_arg
            assign cmd_frame[gi] = addr_reg[39-8*gi -: 8];
        end else begin : g_pad
            assign cmd_frame[gi] = 8'hFF;
        end
    end

    // Byte shifter, SPI mode 0: sample on rising edge, shift on falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            sclk_reg   <= 1'b0;
            div_reg    <= '0;
            bit_reg    <= '0;
            tx_reg     <= 8'hFF;
            rx_reg     <= '0;
        end else if (byte_start) begin
            active_reg <= 1'b1;
            sclk_reg   <= 1'b0;
            div_reg    <= '0;
            bit_reg    <= '0;
            tx_reg     <= tx_byte;
        end else if (active_reg) begin
            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                if (!sclk_reg) begin
                    sclk_reg <= 1'b1;
                    rx_reg   <= {rx_reg[6:0], miso};
                end else begin
                    sclk_reg <= 1'b0;
                    tx_reg   <= {tx_reg[6:0], 1'b1};
                    bit_reg  <= bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        active_reg <= 1'b0;
                    end
                end
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    // Asserted on the 8th falling edge; rx_reg already holds the full byte then.
    assign byte_done = active_reg && sclk_reg && (div_reg == DIV_LAST) && (bit_reg == 3'd7);
    assign sclk      = sclk_reg;
    assign mosi      = active_reg ? tx_reg[7] : 1'b1;
    assign err_code  = err_code_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            pay_cnt_reg  <= '0;
            addr_reg     <= '0;
            err_code_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pay_cnt_reg  <= pay_cnt_next;
            addr_reg     <= addr_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pay_cnt_next  = pay_cnt_reg;
        addr_next     = addr_reg;
        err_code_next = err_code_reg;
        unique case (state_reg)
            S_IDLE: if (start) begin
                state_next    = S_CMD;
                addr_next     = block_addr;
                err_code_next = 3'd0;
                cnt_next      = '0;
                pay_cnt_next  = '0;
            end
            S_CMD: if (byte_done) begin
                if (cnt_reg == 16'd5) begin
                    state_next = S_R1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_R1: if (byte_done) begin
                if (!rx_reg[7]) begin
                    cnt_next = '0;
                    if (rx_reg == 8'h00) begin
                        state_next = S_GAP;
                    end else begin
                        state_next    = S_FAIL;
                        err_code_next = 3'd2;
                    end
                end else if (cnt_reg == RESP_LAST) begin
                    state_next    = S_FAIL;
                    err_code_next = 3'd1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_GAP:   if (byte_done) state_next = S_TOKEN;
            S_TOKEN: if (byte_done) begin
                state_next   = S_DATA;
                pay_cnt_next = '0;
            end
            S_DATA: if (byte_done) begin
                if (pay_cnt_reg == PAY_LAST) begin
                    state_next = S_CRC;
                    cnt_next   = '0;
                end else begin
                    pay_cnt_next = pay_cnt_reg + 16'd1;
                end
            end
            S_CRC: if (byte_done) begin
                if (cnt_reg == 16'd1) begin
                    state_next = S_DRESP;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_DRESP: if (byte_done) begin
                cnt_next = '0;
                if (rx_reg[4:0] == 5'h05) begin
                    state_next = S_BUSYW;
                end else begin
                    state_next    = S_FAIL;
                    err_code_next = 3'd3;
                end
            end
            S_BUSYW: if (byte_done) begin
                if (rx_reg != 8'h00) begin
                    state_next = S_FIN;
                end else if (cnt_reg == BUSY_LAST) begin
                    state_next    = S_FAIL;
                    err_code_next = 3'd4;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_FAIL:  state_next = S_FIN;
            S_FIN:   if (byte_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cs         = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        wr_ready   = 1'b0;
        byte_start = 1'b0;
        tx_byte    = 8'hFF;
        unique case (state_reg)
            S_IDLE: busy = 1'b0;
            S_CMD: begin
                cs         = 1'b0;
                tx_byte    = cmd_frame[cnt_reg[2:0]];
                byte_start = !active_reg;
            end
            S_R1, S_GAP, S_CRC, S_DRESP, S_BUSYW: begin
                cs         = 1'b0;
                byte_start = !active_reg;
            end
            S_TOKEN: begin
                cs         = 1'b0;
                tx_byte    = 8'hFE;
                byte_start = !active_reg;
            end
            // No clocks are issued while the stream has nothing to offer.
            S_DATA: begin
                cs         = 1'b0;
                wr_ready   = !active_reg;
                tx_byte    = wr_data;
                byte_start = !active_reg && wr_valid;
            end
            S_FAIL: cs = 1'b0;
            S_FIN:  byte_start = !active_reg;
            S_DONE: begin
                done  = 1'b1;
                error = (err_code_reg != 3'd0);
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// Bench for sd_block_writer: SD card model on the SPI pins, payload feeder,
// and a scoreboard of expected MOSI bytes checked as each byte completes.
module tb_sd_block_writer;

    localparam int CLK_DIV      = 2;
    localparam int BLOCK_BYTES  = 512;
    localparam int RESP_TIMEOUT = 8;
    localparam int BUSY_TIMEOUT = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] block_addr;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso;

    sd_block_writer #(
        .CLK_DIV      (CLK_DIV),
        .BLOCK_BYTES  (BLOCK_BYTES),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .block_addr (block_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         test_gen = 0;
    int         stall_len = 0;
    int         stall_at = 100;
    logic [7:0] exp_q[$];
    logic [7:0] resp [0:1023];

    int         pay_idx;
    int         hs_cnt;
    bit         ready_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Card model: shifts resp[k] out on MISO for MOSI byte k, and scores MOSI.
    initial begin
        int         mon_gen;
        int         bit_i;
        int         byte_k;
        logic [7:0] mosi_sh;
        logic [7:0] card_sh;
        logic [7:0] e;
        miso    = 1'b1;
        mon_gen = 0;
        bit_i   = 0;
        byte_k  = 0;
        mosi_sh = 8'h00;
        card_sh = 8'hFF;
        forever begin
            @(sclk);
            if (mon_gen != test_gen) begin
                mon_gen = test_gen;
                bit_i   = 0;
                byte_k  = 0;
                card_sh = 8'hFF;
            end
            if (sclk) begin
                mosi_sh = {mosi_sh[6:0], mosi};
                bit_i++;
                if (bit_i == 8) begin
                    bit_i = 0;
                    if (exp_q.size() == 0) begin
                        check_val("mosi_extra", 32'(mosi_sh), 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check_val($sformatf("mosi[%0d]", byte_k), 32'(mosi_sh), 32'(e));
                    end
                    byte_k++;
                end
            end else begin
                if (bit_i == 0) card_sh = (byte_k < 1024) ? resp[byte_k] : 8'hFF;
                miso = card_sh[7-bit_i];
            end
        end
    end

    // Payload feeder: byte n carries n mod 256; optional stall before byte stall_at.
    initial begin
        int fd_gen;
        int stall_left;
        fd_gen     = 0;
        stall_left = 0;
        pay_idx    = 0;
        hs_cnt     = 0;
        ready_seen = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        forever begin
            @(negedge clk);
            if (fd_gen != test_gen) begin
                fd_gen     = test_gen;
                pay_idx    = 0;
                hs_cnt     = 0;
                ready_seen = 1'b0;
                stall_left = stall_len;
            end
            if (wr_ready) ready_seen = 1'b1;
            if (wr_ready && pay_idx == stall_at && stall_left > 0) begin
                wr_valid = 1'b0;
                stall_left--;
                check_val("stall_sclk_cs", 32'({sclk, cs}), 32'd0);
            end else begin
                wr_valid = 1'b1;
                wr_data  = 8'(pay_idx);
                if (wr_ready) begin
                    hs_cnt++;
                    pay_idx++;
                end
            end
        end
    end

    // mode 0 nominal, 1 no R1, 2 R1=0x04, 3 data response rejected.
    task automatic build_txn(input logic [31:0] addr, input int mode,
                             output logic [2:0] exp_code, output int exp_hs);
        for (int i = 0; i < 1024; i++) resp[i] = 8'hFF;
        exp_q.delete();
        exp_q.push_back(8'h58);
        exp_q.push_back(addr[31:24]);
        exp_q.push_back(addr[23:16]);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(8'hFF);
        exp_code = 3'd0;
        exp_hs   = 0;
        if (mode == 1) begin
            for (int i = 0; i < RESP_TIMEOUT; i++) exp_q.push_back(8'hFF);
            exp_code = 3'd1;
        end else if (mode == 2) begin
            resp[6] = 8'h04;
            exp_q.push_back(8'hFF);
            exp_code = 3'd2;
        end else begin
            resp[8] = 8'h00;
            for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int i = 0; i < BLOCK_BYTES; i++) exp_q.push_back(8'(i));
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
            exp_hs = BLOCK_BYTES;
            if (mode == 3) begin
                resp[525] = 8'h0B;
                exp_code  = 3'd3;
            end else begin
                resp[525] = 8'hE5;
                for (int i = 526; i < 529; i++) resp[i] = 8'h00;
                for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
            end
        end
        exp_q.push_back(8'hFF);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic kick(input logic [31:0] addr);
        @(negedge clk);
        block_addr = addr;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        block_addr = ~addr;
        check_val("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_txn(input int id, input logic [31:0] addr, input int mode, input int stall);
        logic [2:0] exp_code;
        int         exp_hs;
        bit         seen;
        build_txn(addr, mode, exp_code, exp_hs);
        stall_len = stall;
        test_gen++;
        kick(addr);
        repeat (10) @(negedge clk);
        start      = 1'b1;
        block_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("error", 32'(error), 32'(exp_code != 3'd0));
        check_val("err_code", 32'(err_code), 32'(exp_code));
        check_val("cs_at_done", 32'(cs), 32'd1);
        check_val("handshakes", 32'(hs_cnt), 32'(exp_hs));
        check_val("ready_seen", 32'(ready_seen), 32'(exp_hs != 0));
        check_val("mosi_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_val("after_done_done_busy", 32'({done, busy}), 32'd0);
        check_val("err_code_held", 32'(err_code), 32'(exp_code));
        $display("txn %0d: addr=%08h err_code=%0d handshakes=%0d stall=%0d",
                 id, addr, err_code, hs_cnt, stall);
    endtask

    task automatic run_abort(input int id);
        logic [2:0] exp_code;
        int         exp_hs;
        build_txn(32'h0000_1234, 0, exp_code, exp_hs);
        stall_len = 0;
        test_gen++;
        kick(32'h0000_1234);
        for (int c = 0; c < 20000 && hs_cnt < 300; c++) @(negedge clk);
        check_val("abort_point", 32'(hs_cnt), 32'd300);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_cs", 32'(cs), 32'd1);
        check_val("arst_sclk", 32'(sclk), 32'd0);
        check_val("arst_mosi", 32'(mosi), 32'd1);
        check_val("arst_busy_ready", 32'({busy, wr_ready}), 32'd0);
        check_val("arst_err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn %0d: reset asserted after %0d handshakes", id, hs_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        block_addr = 32'h0;
        #1;
        check_val("rst_cs_sclk_mosi", 32'({cs, sclk, mosi}), 32'b101);
        check_val("rst_ready_busy_done_err", 32'({wr_ready, busy, done, error}), 32'd0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(1, 32'h0000_1234, 0, 0);
        run_txn(2, 32'h0000_ABCD, 1, 0);
        run_txn(3, 32'h0000_0200, 2, 0);
        run_txn(4, 32'h0000_1000, 3, 0);
        run_txn(5, 32'hDEAD_BEEF, 0, 20);
        run_abort(6);
        run_txn(7, 32'h0000_1234, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
